// File: rtl/complex_result_accumulator.sv
// Sums acc_len consecutive complex products from the multiplier into one complex result.
// Optional macro ACC_SATURATE_EN: sticky per-component saturation instead of wrap-around.
module complex_result_accumulator #(
  parameter  int DATA_WIDTH = 8,
  parameter  int GUARD_BITS = 4,
  parameter  int CNT_WIDTH  = 5,
  localparam int PROD_WIDTH = 2 * DATA_WIDTH,
  localparam int ACC_WIDTH  = 2 * DATA_WIDTH + GUARD_BITS
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sw_rst,
  input  logic [CNT_WIDTH-1:0]  acc_len,
  input  logic                  res_val,
  output logic                  res_ready,
  input  logic [PROD_WIDTH-1:0] result_re,
  input  logic [PROD_WIDTH-1:0] result_im,
  output logic                  acc_val,
  input  logic                  acc_ready,
  output logic [ACC_WIDTH-1:0]  acc_re,
  output logic [ACC_WIDTH-1:0]  acc_im,
  output logic [CNT_WIDTH-1:0]  acc_cnt,
  output logic [1:0]            dbg_state
);

  // Handshakes: a product moves on an edge with res_val & res_ready, a sum with
  // acc_val & acc_ready; both ready/valid outputs decode registered state only.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc_re_q, acc_im_q;
  logic [CNT_WIDTH-1:0] cnt_q, len_q;
  logic [ACC_WIDTH-1:0] ext_re, ext_im;
  logic [ACC_WIDTH-1:0] add_re, add_im;
  logic                 prod_xfer;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [CNT_WIDTH-1:0] len_eff;

  assign ext_re    = {{GUARD_BITS{result_re[PROD_WIDTH-1]}}, result_re};
  assign ext_im    = {{GUARD_BITS{result_im[PROD_WIDTH-1]}}, result_im};
  assign prod_xfer = res_val & res_ready;
  assign cnt_next  = cnt_q + 1'b1;
  assign len_eff   = (acc_len == '0) ? CNT_WIDTH'(1) : acc_len;

`ifdef ACC_SATURATE_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic sat_re_q, sat_im_q;
  logic clamp_re, clamp_im;

  // Returns {clamped, value}; overflow shows as disagreeing top two bits of the wide sum.
  function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                 input logic [ACC_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return {1'b1, (s[ACC_WIDTH] ? ACC_MIN : ACC_MAX)};
    return {1'b0, s[ACC_WIDTH-1:0]};
  endfunction

  always_comb begin
    {clamp_re, add_re} = sat_add(acc_re_q, ext_re);
    {clamp_im, add_im} = sat_add(acc_im_q, ext_im);
    // A clamped component is frozen for the rest of the frame.
    if (sat_re_q) begin
      add_re   = acc_re_q;
      clamp_re = 1'b1;
    end
    if (sat_im_q) begin
      add_im   = acc_im_q;
      clamp_im = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sat_re_q <= 1'b0;
      sat_im_q <= 1'b0;
    end else if (sw_rst || state == IDLE) begin
      sat_re_q <= 1'b0;
      sat_im_q <= 1'b0;
    end else if (state == ACCUM && prod_xfer) begin
      sat_re_q <= clamp_re;
      sat_im_q <= clamp_im;
    end
  end
`else
  always_comb begin
    add_re = acc_re_q + ext_re;
    add_im = acc_im_q + ext_im;
  end
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      acc_re_q <= '0;
      acc_im_q <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
    end else if (sw_rst) begin
      state    <= IDLE;
      acc_re_q <= '0;
      acc_im_q <= '0;
      cnt_q    <= '0;
      len_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (prod_xfer) begin
            len_q    <= len_eff;
            acc_re_q <= ext_re;
            acc_im_q <= ext_im;
            cnt_q    <= CNT_WIDTH'(1);
            state    <= (len_eff == CNT_WIDTH'(1)) ? OUT : ACCUM;
          end
        end
        ACCUM: begin
          if (prod_xfer) begin
            acc_re_q <= add_re;
            acc_im_q <= add_im;
            cnt_q    <= cnt_next;
            if (cnt_next == len_q) state <= OUT;
          end
        end
        OUT: begin
          if (acc_ready) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
            cnt_q    <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign res_ready = (state != OUT);
  assign acc_val   = (state == OUT);
  assign acc_re    = acc_re_q;
  assign acc_im    = acc_im_q;
  assign acc_cnt   = cnt_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_complex_result_accumulator.sv
// Directed self-checking bench for complex_result_accumulator (default 8/4/5 parameters).
// Build with ACC_SATURATE_EN defined to check the saturating variant.
module tb_complex_result_accumulator;

  localparam int DW = 8;
  localparam int GB = 4;
  localparam int CW = 5;
  localparam int PW = 2 * DW;
  localparam int AW = 2 * DW + GB;

  logic          clk = 1'b0;
  logic          rstn;
  logic          sw_rst;
  logic [CW-1:0] acc_len;
  logic          res_val;
  logic          res_ready;
  logic [PW-1:0] result_re, result_im;
  logic          acc_val;
  logic          acc_ready;
  logic [AW-1:0] acc_re, acc_im;
  logic [CW-1:0] acc_cnt;
  logic [1:0]    dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  complex_result_accumulator #(.DATA_WIDTH(DW), .GUARD_BITS(GB), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sw_rst    (sw_rst),
    .acc_len   (acc_len),
    .res_val   (res_val),
    .res_ready (res_ready),
    .result_re (result_re),
    .result_im (result_im),
    .acc_val   (acc_val),
    .acc_ready (acc_ready),
    .acc_re    (acc_re),
    .acc_im    (acc_im),
    .acc_cnt   (acc_cnt),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] z(input logic [AW-1:0] v);
    return {{(32-AW){1'b0}}, v};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: present one product and hold it until it is transferred.
  task automatic send(input logic [PW-1:0] re, input logic [PW-1:0] im);
    int n;
    n = 0;
    res_val   = 1'b1;
    result_re = re;
    result_im = im;
    while (!res_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", 32'(res_ready), 32'd1);
    tick();
    res_val   = 1'b0;
    result_re = PW'($urandom_range(0, 65535));
    result_im = PW'($urandom_range(0, 65535));
  endtask

  task automatic check_sum(input string tag, input logic [AW-1:0] re,
                           input logic [AW-1:0] im, input int cnt);
    check({tag, "_val"}, 32'(acc_val), 32'd1);
    check({tag, "_re"},  z(acc_re), z(re));
    check({tag, "_im"},  z(acc_im), z(im));
    check({tag, "_cnt"}, 32'(acc_cnt), 32'(cnt));
  endtask

  task automatic take_sum(input string tag);
    acc_ready = 1'b1;
    tick();
    acc_ready = 1'b0;
    check({tag, "_taken"}, 32'(acc_val), 32'd0);
    check({tag, "_clr"},   z(acc_re), z('0));
  endtask

  initial begin
    rstn      = 1'b0;
    sw_rst    = 1'b0;
    acc_len   = '0;
    res_val   = 1'b0;
    result_re = '0;
    result_im = '0;
    acc_ready = 1'b0;
    #12;
    check("rst_val",   32'(acc_val), 32'd0);
    check("rst_ready", 32'(res_ready), 32'd1);
    check("rst_re",    z(acc_re), z('0));
    check("rst_cnt",   32'(acc_cnt), 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // 1: async reset mid-frame, then a clean 4-product frame
    acc_len = 5'd4;
    send(16'd9, 16'd9);
    send(16'd9, 16'd9);
    #2 rstn = 1'b0;
    #1;
    check("t1_val",   32'(acc_val), 32'd0);
    check("t1_ready", 32'(res_ready), 32'd1);
    check("t1_re",    z(acc_re), z('0));
    check("t1_cnt",   32'(acc_cnt), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send(16'd1, 16'd1);
    check_sum("t1", 20'd4, 20'd4, 4);
    take_sum("t1");

    // 2: basic 3-product sum, sum visible one cycle after the last transfer
    acc_len = 5'd3;
    send(16'd100, -16'sd5);
    check("t2_mid_val", 32'(acc_val), 32'd0);
    send(-16'sd300, 16'd7);
    send(16'd50, 16'd2);
    check_sum("t2", -20'sd150, 20'd4, 3);
    take_sum("t2");

    // 3: output backpressure holds data and blocks products
    acc_len = 5'd1;
    send(16'h1234, 16'h0001);
    for (int i = 0; i < 5; i++) begin
      check_sum("t3_hold", 20'h01234, 20'h00001, 1);
      check("t3_ready", 32'(res_ready), 32'd0);
      tick();
    end
    acc_ready = 1'b1;
    res_val   = 1'b1;
    result_re = 16'd2;
    result_im = 16'd3;
    tick();
    check("t3_after_val",   32'(acc_val), 32'd0);
    check("t3_after_ready", 32'(res_ready), 32'd1);
    acc_ready = 1'b0;
    tick();
    res_val = 1'b0;
    check_sum("t3_next", 20'd2, 20'd3, 1);
    take_sum("t3");

    // 4: length 0 behaves as 1; gaps and mid-frame acc_len change
    acc_len = 5'd0;
    send(16'd7, -16'sd7);
    check_sum("t4_len0", 20'd7, -20'sd7, 1);
    take_sum("t4a");
    acc_len = 5'd2;
    send(16'd10, 16'd20);
    acc_len = 5'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_gap_val", 32'(acc_val), 32'd0);
      check("t4_gap_cnt", 32'(acc_cnt), 32'd1);
    end
    send(-16'sd3, 16'd5);
    check_sum("t4_gap", 20'd7, 20'd25, 2);
    take_sum("t4b");

    // 5: 17 extreme products overflow the 20-bit accumulator
    acc_len = 5'd17;
    for (int i = 0; i < 17; i++) send(16'h7FFF, 16'h8000);
`ifdef ACC_SATURATE_EN
    check_sum("t5_sat", 20'h7FFFF, 20'h80000, 17);
`else
    check_sum("t5_wrap", 20'h87FEF, 20'h78000, 17);
`endif
    take_sum("t5");

    // 6: software reset drops a pending sum
    acc_len = 5'd2;
    send(16'd5, 16'd6);
    send(16'd7, 16'd8);
    check_sum("t6_pre", 20'd12, 20'd14, 2);
    sw_rst = 1'b1;
    tick();
    sw_rst = 1'b0;
    check("t6_val",   32'(acc_val), 32'd0);
    check("t6_re",    z(acc_re), z('0));
    check("t6_im",    z(acc_im), z('0));
    check("t6_cnt",   32'(acc_cnt), 32'd0);
    check("t6_ready", 32'(res_ready), 32'd1);
    check("t6_state", 32'(dbg_state), 32'd0);
    acc_len = 5'd1;
    send(16'd3, 16'd4);
    check_sum("t6_new", 20'd3, 20'd4, 1);
    take_sum("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
